// File: rtl/seq_unlock_pkg.sv
// Shared types and helpers for the read-sequence unlock detector.
// State encoding, status bit layout and key-entry extraction.
package seq_unlock_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MATCHING,
    UNLOCKED
  } state_t;

  localparam int unsigned KEY_MAX_W  = 128;
  localparam int unsigned KEY_MAX_AW = 8;
  localparam int unsigned CNT_W      = 16;

  localparam int unsigned ST_IDX_LSB = 0;

  function automatic int unsigned st_unlock_pos(
    input int unsigned dw
  );
    return dw - 1;
  endfunction

  // Entry i of a packed key, entry 0 in the LSBs.
  function automatic logic [KEY_MAX_AW-1:0] key_entry(
    input logic [KEY_MAX_W-1:0] key,
    input int unsigned          i,
    input int unsigned          aw
  );
    logic [KEY_MAX_W-1:0]  sh;
    logic [KEY_MAX_AW-1:0] mask;
    sh   = key >> (i * aw);
    mask = (KEY_MAX_AW'(1) << aw) - KEY_MAX_AW'(1);
    return sh[KEY_MAX_AW-1:0] & mask;
  endfunction

endpackage

// File: rtl/seq_unlock_detector_timeout.sv
// Load-clear inactivity counter with a terminal flag.
// term marks the edge on which the count reaches LIMIT-1.
module sud_timeout
  import seq_unlock_pkg::*;
#(
  parameter int unsigned LIMIT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic term
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign term = (cnt_q == CNT_W'(LIMIT - 2));

endmodule

// File: rtl/seq_unlock_detector.sv
// Unlocks after a keyed sequence of reads; relocks on RELOCK_ADDR.
// Optional MATCHING timeout enabled by macro SEQ_UNLOCK_TIMEOUT_EN.
module seq_unlock_detector
  import seq_unlock_pkg::*;
#(
  parameter int unsigned SEQ_LEN = 6,
  parameter int unsigned ADDR_W  = 4,
  parameter logic [SEQ_LEN*ADDR_W-1:0] KEY = 24'h95A3C2,
  parameter logic [ADDR_W-1:0] RELOCK_ADDR = 4'hF,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       bus_valid,
  input  logic                       bus_sel,
  input  logic                       bus_rw,
  input  logic [ADDR_W-1:0]          bus_addr,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_data_oe,
  output logic                       unlocked,
  output logic [$clog2(SEQ_LEN+1)-1:0] progress
);

  localparam int unsigned IDX_W = $clog2(SEQ_LEN + 1);
  localparam logic [KEY_MAX_W-1:0] KEY_EXT = KEY_MAX_W'(KEY);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(SEQ_LEN - 1);
  localparam int unsigned UNL_POS = st_unlock_pos(DATA_W);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             unlocked_q;

  logic rd_acc, wr_acc, expire;
  logic hit_cur, hit_first, hit_relock;
  logic [KEY_MAX_AW-1:0] addr_ext, key_cur, key_first;

  assign rd_acc = bus_valid & bus_sel & bus_rw;
  assign wr_acc = bus_valid & bus_sel & ~bus_rw;

  assign addr_ext   = KEY_MAX_AW'(bus_addr);
  assign key_cur    = key_entry(KEY_EXT, 32'(idx_q), ADDR_W);
  assign key_first  = key_entry(KEY_EXT, 0, ADDR_W);
  assign hit_cur    = (addr_ext == key_cur);
  assign hit_first  = (addr_ext == key_first);
  assign hit_relock = (bus_addr == RELOCK_ADDR);

`ifdef SEQ_UNLOCK_TIMEOUT_EN
  logic to_term, to_clr, in_match;

  assign in_match = (state_q == MATCHING);
  assign to_clr   = rd_acc |
                    (!in_match && state_d == MATCHING);

  sud_timeout #(
    .LIMIT (TIMEOUT_CYC)
  ) u_timeout (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (to_clr),
    .en    (in_match),
    .term  (to_term)
  );

  assign expire = to_term & in_match & ~rd_acc & ~wr_acc;
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (1'b1)
      wr_acc: begin
        state_d = IDLE;
        idx_d   = '0;
      end
      rd_acc: begin
        unique case (state_q)
          IDLE: begin
            if (hit_first) begin
              state_d = MATCHING;
              idx_d   = IDX_W'(1);
            end
          end
          // Relock address is only meaningful once unlocked.
          MATCHING: begin
            if (hit_cur) begin
              if (idx_q == LAST) begin
                state_d = UNLOCKED;
                idx_d   = '0;
              end else begin
                idx_d = idx_q + IDX_W'(1);
              end
            end else if (hit_first) begin
              idx_d = IDX_W'(1);
            end else begin
              state_d = IDLE;
              idx_d   = '0;
            end
          end
          UNLOCKED: begin
            if (hit_relock) begin
              state_d = IDLE;
            end
          end
          default: begin
            state_d = IDLE;
            idx_d   = '0;
          end
        endcase
      end
      expire: begin
        state_d = IDLE;
        idx_d   = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      unlocked_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      unlocked_q <= (state_d == UNLOCKED);
    end
  end

  assign rd_data_oe = rd_acc;
  assign unlocked   = unlocked_q;
  assign progress   = idx_q;

  // Read-back reflects state before this access takes effect.
  always_comb begin
    rd_data = '0;
    if (rd_data_oe) begin
      rd_data[ST_IDX_LSB +: IDX_W] = idx_q;
      rd_data[UNL_POS]             = unlocked_q;
    end
  end

endmodule

// File: tb/tb_seq_unlock_detector.sv
// Directed vector bench for seq_unlock_detector (default key 2,C,3,A,5,9).
module tb_seq_unlock_detector;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       bus_valid, bus_sel, bus_rw;
  logic [3:0] bus_addr;
  logic [7:0] rd_data;
  logic       rd_data_oe;
  logic       unlocked;
  logic [2:0] progress;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_unlock_detector #(
    .TIMEOUT_CYC (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus_valid  (bus_valid),
    .bus_sel    (bus_sel),
    .bus_rw     (bus_rw),
    .bus_addr   (bus_addr),
    .rd_data    (rd_data),
    .rd_data_oe (rd_data_oe),
    .unlocked   (unlocked),
    .progress   (progress)
  );

  typedef struct {
    logic       v;
    logic       s;
    logic       rw;
    logic [3:0] a;
    logic       oe;
    logic [7:0] rd;
    logic       u;
    logic [2:0] p;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_cycle(input logic v, input logic s, input logic rw,
                          input logic [3:0] a, input logic eoe,
                          input logic [7:0] erd, input logic eu,
                          input logic [2:0] ep, input string nm);
    @(negedge clk);
    bus_valid = v;
    bus_sel   = s;
    bus_rw    = rw;
    bus_addr  = a;
    #1;
    chk({nm, ".oe"}, 32'(rd_data_oe), 32'(eoe));
    chk({nm, ".rd"}, 32'(rd_data), 32'(erd));
    @(posedge clk);
    #1;
    chk({nm, ".unl"}, 32'(unlocked), 32'(eu));
    chk({nm, ".prog"}, 32'(progress), 32'(ep));
    bus_valid = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] erd,
                    input logic eu, input logic [2:0] ep,
                    input string nm);
    do_cycle(1'b1, 1'b1, 1'b1, a, 1'b1, erd, eu, ep, nm);
  endtask

  task automatic idle(input logic eu, input logic [2:0] ep,
                      input string nm);
    do_cycle(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 8'h00, eu, ep, nm);
  endtask

  initial begin
    //          v  s  rw a     oe rd     u  p
    tbl.push_back('{1, 1, 1, 4'h2, 1, 8'h00, 0, 1});
    tbl.push_back('{1, 1, 1, 4'hC, 1, 8'h01, 0, 2});
    tbl.push_back('{1, 1, 1, 4'h3, 1, 8'h02, 0, 3});
    tbl.push_back('{0, 0, 0, 4'h0, 0, 8'h00, 0, 3});
    tbl.push_back('{1, 0, 1, 4'hA, 0, 8'h00, 0, 3});
    tbl.push_back('{1, 1, 1, 4'hA, 1, 8'h03, 0, 4});
    tbl.push_back('{1, 1, 1, 4'h5, 1, 8'h04, 0, 5});
    tbl.push_back('{1, 1, 1, 4'h9, 1, 8'h05, 1, 0});
    tbl.push_back('{1, 1, 1, 4'h3, 1, 8'h80, 1, 0});
    tbl.push_back('{1, 1, 1, 4'hF, 1, 8'h80, 0, 0});
    tbl.push_back('{1, 1, 1, 4'h2, 1, 8'h00, 0, 1});
    tbl.push_back('{1, 1, 1, 4'hC, 1, 8'h01, 0, 2});
    tbl.push_back('{1, 1, 1, 4'h7, 1, 8'h02, 0, 0});
    tbl.push_back('{1, 1, 1, 4'h2, 1, 8'h00, 0, 1});
    tbl.push_back('{1, 1, 1, 4'hC, 1, 8'h01, 0, 2});
    tbl.push_back('{1, 1, 1, 4'h2, 1, 8'h02, 0, 1});
    tbl.push_back('{1, 1, 1, 4'hC, 1, 8'h01, 0, 2});
    tbl.push_back('{1, 0, 0, 4'h0, 0, 8'h00, 0, 2});
    tbl.push_back('{1, 1, 1, 4'h3, 1, 8'h02, 0, 3});
    tbl.push_back('{1, 1, 0, 4'h3, 0, 8'h00, 0, 0});
    tbl.push_back('{1, 1, 1, 4'hF, 1, 8'h00, 0, 0});

    rst_n     = 1'b0;
    bus_valid = 1'b0;
    bus_sel   = 1'b0;
    bus_rw    = 1'b0;
    bus_addr  = 4'h0;
    #2;
    chk("rst.prog", 32'(progress), 32'd0);
    chk("rst.unl", 32'(unlocked), 32'd0);
    chk("rst.oe", 32'(rd_data_oe), 32'd0);
    bus_valid = 1'b1;
    bus_sel   = 1'b1;
    bus_rw    = 1'b1;
    bus_addr  = 4'h2;
    #1;
    chk("rst.oe_rd", 32'(rd_data_oe), 32'd1);
    chk("rst.rd", 32'(rd_data), 32'd0);
    bus_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      do_cycle(tbl[i].v, tbl[i].s, tbl[i].rw, tbl[i].a,
               tbl[i].oe, tbl[i].rd, tbl[i].u, tbl[i].p,
               $sformatf("vec%0d", i));
    end

    // Asynchronous reset in the middle of a sequence.
    rd(4'h2, 8'h00, 0, 1, "ar.r0");
    rd(4'hC, 8'h01, 0, 2, "ar.r1");
    rd(4'h3, 8'h02, 0, 3, "ar.r2");
    rd(4'hA, 8'h03, 0, 4, "ar.r3");
    #2;
    bus_valid = 1'b1;
    bus_sel   = 1'b1;
    bus_rw    = 1'b1;
    bus_addr  = 4'h5;
    rst_n     = 1'b0;
    #1;
    chk("ar.prog", 32'(progress), 32'd0);
    chk("ar.unl", 32'(unlocked), 32'd0);
    chk("ar.oe", 32'(rd_data_oe), 32'd1);
    chk("ar.rd", 32'(rd_data), 32'd0);
    bus_valid = 1'b0;
    #1;
    rst_n = 1'b1;
    rd(4'h5, 8'h00, 0, 0, "ar.post5");
    rd(4'h2, 8'h00, 0, 1, "ar.s0");
    rd(4'hC, 8'h01, 0, 2, "ar.s1");
    rd(4'h3, 8'h02, 0, 3, "ar.s2");
    rd(4'hA, 8'h03, 0, 4, "ar.s3");
    rd(4'h5, 8'h04, 0, 5, "ar.s4");
    rd(4'h9, 8'h05, 1, 0, "ar.s5");
    rd(4'hF, 8'h80, 0, 0, "ar.relock");

`ifdef SEQ_UNLOCK_TIMEOUT_EN
    rd(4'h2, 8'h00, 0, 1, "to.r0");
    for (int k = 1; k <= 14; k++) idle(0, 1, $sformatf("to.i%0d", k));
    idle(0, 0, "to.expire");
    rd(4'h2, 8'h00, 0, 1, "to.r1");
    for (int k = 1; k <= 14; k++) idle(0, 1, $sformatf("to.j%0d", k));
    rd(4'hC, 8'h01, 0, 2, "to.edge");
    do_cycle(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 8'h00, 0, 0, "to.wr");
`else
    rd(4'h2, 8'h00, 0, 1, "nt.r0");
    for (int k = 1; k <= 40; k++) idle(0, 1, $sformatf("nt.i%0d", k));
    rd(4'hC, 8'h01, 0, 2, "nt.r1");
    do_cycle(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 8'h00, 0, 0, "nt.wr");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
